// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
// State encoding and requester ids live here so all files agree.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// Two-way round-robin arbiter: grants on request, pointer moves
// to the other requester after every grant.
module rr_arbiter2
    import ram_port_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_ptr;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            unique case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_ptr == REQ1) ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= REQ0;
        end else if (|w_gnt) begin
            r_ptr <= w_gnt[0] ? REQ1 : REQ0;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two requesters and
// sequences the whole-array clear at power-up and on request.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  clear_done,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_WIDTH-1:0]  acc_cnt0,
    output logic [CNT_WIDTH-1:0]  acc_cnt1,
    output logic                  ram_reset,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_read_or_write,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_clear_done;
    logic                  r_rd_pend;
    logic                  r_rd_id;
    logic [CNT_WIDTH-1:0]  r_cnt0;
    logic [CNT_WIDTH-1:0]  r_cnt1;
    logic                  w_arb_en;
    logic [1:0]            w_gnt;
    logic                  w_rd_issue;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // A clear request in RUN takes the cycle away from arbitration.
    always_comb begin
        w_next   = r_state;
        w_arb_en = 1'b0;
        unique case (r_state)
            INIT:    w_next = RUN;
            RUN: begin
                if (clear_req) begin
                    w_next = CLEAR;
                end else begin
                    w_arb_en = 1'b1;
                end
            end
            CLEAR:   w_next = RUN;
            default: w_next = INIT;
        endcase
    end

    rr_arbiter2 u_arb (
        .clock (clock),
        .reset (reset),
        .i_en  (w_arb_en),
        .i_req ({req1, req0}),
        .o_gnt (w_gnt)
    );

    assign gnt0 = w_gnt[0];
    assign gnt1 = w_gnt[1];

    always_comb begin
        ram_address       = '0;
        ram_read_or_write = 1'b0;
        ram_data_in       = '0;
        if (w_gnt[0]) begin
            ram_address       = addr0;
            ram_read_or_write = we0;
            ram_data_in       = wdata0;
        end else if (w_gnt[1]) begin
            ram_address       = addr1;
            ram_read_or_write = we1;
            ram_data_in       = wdata1;
        end
    end

    assign ram_reset  = (r_state == INIT) || (r_state == CLEAR);
    assign w_rd_issue = (w_gnt[0] && !we0) || (w_gnt[1] && !we1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clear_done <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_id      <= REQ0;
        end else begin
            r_clear_done <= ram_reset;
            r_rd_pend    <= w_rd_issue;
            if (|w_gnt) begin
                r_rd_id <= w_gnt[1] ? REQ1 : REQ0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt[0] && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
            end
            if (w_gnt[1] && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

    assign clear_done = r_clear_done;
    assign rvalid0    = r_rd_pend && (r_rd_id == REQ0);
    assign rvalid1    = r_rd_pend && (r_rd_id == REQ1);
    assign rdata      = r_rd_pend ? ram_data_out : '0;
    assign acc_cnt0   = r_cnt0;
    assign acc_cnt1   = r_cnt1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench with grant/read scoreboard for ram_port_arbiter,
// including a behavioural single-port RAM with whole-array clear.
module tb_ram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear_req = 1'b0;
    logic          clear_done;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic          we0 = 1'b0;
    logic          we1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata0 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic [CW-1:0] acc_cnt0;
    logic [CW-1:0] acc_cnt1;
    logic          ram_reset;
    logic [AW-1:0] ram_address;
    logic          ram_read_or_write;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;

    logic [DW-1:0] mem [2**AW];

    typedef struct {
        int            id;
        logic [DW-1:0] d;
    } rd_t;

    int  q_gnt[$];
    rd_t q_rd[$];
    int  total = 0;
    int  bad = 0;

    always #5 clock = ~clock;

    ram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .clear_req         (clear_req),
        .clear_done        (clear_done),
        .req0              (req0),
        .req1              (req1),
        .we0               (we0),
        .we1               (we1),
        .addr0             (addr0),
        .addr1             (addr1),
        .wdata0            (wdata0),
        .wdata1            (wdata1),
        .gnt0              (gnt0),
        .gnt1              (gnt1),
        .rvalid0           (rvalid0),
        .rvalid1           (rvalid1),
        .rdata             (rdata),
        .acc_cnt0          (acc_cnt0),
        .acc_cnt1          (acc_cnt1),
        .ram_reset         (ram_reset),
        .ram_address       (ram_address),
        .ram_read_or_write (ram_read_or_write),
        .ram_data_in       (ram_data_in),
        .ram_data_out      (ram_data_out)
    );

    always @(posedge clock) begin
        if (ram_reset) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (ram_read_or_write) begin
            mem[ram_address] <= ram_data_in;
        end
        ram_data_out <= mem[ram_address];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        int  e;
        rd_t r;
        if (gnt0 || gnt1) begin
            if (q_gnt.size() == 0) begin
                chk("gnt_unexpected", 32'({gnt1, gnt0}), 32'(0));
            end else begin
                e = q_gnt.pop_front();
                chk("gnt_order", 32'({gnt1, gnt0}), 32'((e == 0) ? 1 : 2));
            end
        end
        if (rvalid0 || rvalid1) begin
            if (q_rd.size() == 0) begin
                chk("rvalid_unexpected", 32'({rvalid1, rvalid0}), 32'(0));
            end else begin
                r = q_rd.pop_front();
                chk("rvalid_id", 32'({rvalid1, rvalid0}),
                    32'((r.id == 0) ? 1 : 2));
                chk("rdata", 32'(rdata), 32'(r.d));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // For reads, d is the data the scoreboard expects back.
    task automatic access(input int id, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        q_gnt.push_back(id);
        if (!w) q_rd.push_back('{id, d});
        if (id == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
        n = 0;
        @(negedge clock);
        while (!((id == 0) ? gnt0 : gnt1) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) chk("grant_timeout", 32'(n), 32'(0));
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        clear_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("init_ram_reset", 32'(ram_reset), 32'(1));
        tick();
        @(negedge clock);
        chk("init_clear_done", 32'(clear_done), 32'(1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up: reset held, then one INIT cycle with a request waiting
        tick();
        tick();
        @(negedge clock);
        chk("rst_ram_reset", 32'(ram_reset), 32'(1));
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'(0));
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
        chk("rst_clear_done", 32'(clear_done), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        chk("rst_cnt", 32'({acc_cnt1, acc_cnt0}), 32'(0));
        chk("rst_rw", 32'(ram_read_or_write), 32'(0));
        tick();
        reset = 1'b0;
        q_gnt.push_back(0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 4'hA;
        @(negedge clock);
        chk("init_ram_reset", 32'(ram_reset), 32'(1));
        chk("init_no_gnt", 32'(gnt0), 32'(0));
        chk("init_no_done", 32'(clear_done), 32'(0));
        tick();
        @(negedge clock);
        chk("run_ram_reset", 32'(ram_reset), 32'(0));
        chk("run_clear_done", 32'(clear_done), 32'(1));
        chk("wr_addr", 32'(ram_address), 32'(8'h05));
        chk("wr_strobe", 32'(ram_read_or_write), 32'(1));
        chk("wr_data", 32'(ram_data_in), 32'(4'hA));
        tick();
        req0 = 1'b0;
        @(negedge clock);
        chk("done_pulse", 32'(clear_done), 32'(0));
        chk("idle_addr", 32'(ram_address), 32'(0));
        tick();
        access(0, 1'b0, 8'h05, 4'hA);
        @(negedge clock);
        chk("cnt0_wr_rd", 32'(acc_cnt0), 32'(2));

        // Contention: both writing for four cycles
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 4'h1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 4'h2;
        q_gnt.push_back(0);
        q_gnt.push_back(1);
        q_gnt.push_back(0);
        q_gnt.push_back(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clock);
        chk("cont_cnt0", 32'(acc_cnt0), 32'(2));
        chk("cont_cnt1", 32'(acc_cnt1), 32'(2));
        tick();

        // Pipelined alternating reads
        access(0, 1'b1, 8'h01, 4'h3);
        access(1, 1'b1, 8'h02, 4'hC);
        q_gnt.push_back(0);
        q_gnt.push_back(1);
        q_rd.push_back('{0, 4'h3});
        q_rd.push_back('{1, 4'hC});
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
        @(negedge clock);
        tick();
        req0 = 1'b0;
        @(negedge clock);
        tick();
        req1 = 1'b0;
        @(negedge clock);
        chk("pipe_cnt0", 32'(acc_cnt0), 32'(4));
        chk("pipe_cnt1", 32'(acc_cnt1), 32'(4));
        tick();

        // Clear request colliding with a req1 read
        access(0, 1'b1, 8'h05, 4'hA);
        clear_req = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
        q_gnt.push_back(1);
        q_rd.push_back('{1, 4'h0});
        @(negedge clock);
        chk("clr_no_gnt", 32'({gnt1, gnt0}), 32'(0));
        tick();
        clear_req = 1'b0;
        @(negedge clock);
        chk("clr_ram_reset", 32'(ram_reset), 32'(1));
        chk("clr_no_gnt2", 32'({gnt1, gnt0}), 32'(0));
        chk("clr_done_early", 32'(clear_done), 32'(0));
        tick();
        @(negedge clock);
        chk("clr_done", 32'(clear_done), 32'(1));
        chk("clr_ram_reset_off", 32'(ram_reset), 32'(0));
        tick();
        req1 = 1'b0;
        @(negedge clock);
        chk("clr_cnt0_kept", 32'(acc_cnt0), 32'(5));
        tick();

        // Reset in the cycle of a granted read drops its response
        q_gnt.push_back(0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        reset = 1'b1;
        @(negedge clock);
        tick();
        req0 = 1'b0;
        @(negedge clock);
        chk("rst_drop_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
        chk("rst_cnt_clr", 32'({acc_cnt1, acc_cnt0}), 32'(0));
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rerun_init", 32'(ram_reset), 32'(1));
        tick();
        tick();

        // Saturation of the 4-bit counter
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 4'h7;
        for (int i = 0; i < 20; i++) q_gnt.push_back(0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("sat_cnt0", 32'(acc_cnt0), 32'((i < 15) ? i : 15));
            tick();
        end
        req0 = 1'b0;
        @(negedge clock);
        chk("sat_final0", 32'(acc_cnt0), 32'(4'hF));
        chk("sat_final1", 32'(acc_cnt1), 32'(0));
        tick();
        tick();

        chk("gnt_queue_empty", 32'(q_gnt.size()), 32'(0));
        chk("rd_queue_empty", 32'(q_rd.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
